fetch_aligner: RTL and testbench
================================

# fetch_aligner

Instruction fetch and realignment stage feeding the decoder / `control` stage of the 3-stage core. It issues word-aligned requests to instruction memory and buffers the returned halfwords in a 4-entry queue. From that queue it presents one complete instruction per cycle, either 16-bit compressed or 32-bit, with its PC. It also absorbs branch, jump and trap redirects from the execute/CSR stage.

## Interface
Parameters:
- `XLEN`, 32: address/data width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset (word-aligned).

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `imem_req_o` out 1: fetch request this cycle.
- `imem_addr_o` out XLEN: word-aligned fetch address; bits [1:0] are always 0.
- `imem_rdata_i` in 32: fetched word.
- `imem_valid_i` in 1: `imem_rdata_i` valid. It answers the request of the previous cycle (fixed 1-cycle latency).
- `redirect_i` in 1: flush and restart fetch.
- `redirect_pc_i` in XLEN: new PC, halfword-aligned.
- `stall_i` in 1: downstream cannot accept; the head instruction is held.
- `instr_valid_o` out 1: `instr_o` holds a complete instruction.
- `instr_o` out 32: instruction. A compressed instruction appears in [15:0] with [31:16] = 0.
- `instr_is_c_o` out 1: head instruction is 16-bit (bits [1:0] != 2'b11).
- `instr_pc_o` out XLEN: PC of the head instruction.

## Operation
- Queue: 4 halfword entries, `count` ranges 0..4, plus `head_pc`.
- Length of the head instruction: head[1:0] == 2'b11 means 2 halfwords, otherwise 1.
- `instr_valid_o` = (count ≥ 1 and head compressed) or (count ≥ 2).
- A 32-bit instruction may straddle two fetched words, e.g. at PC 0x2. It becomes valid only when both halves are queued.
- Pop: when `instr_valid_o` is high and `stall_i` is low, remove 1 or 2 halfwords and advance `head_pc` by 2 or 4.
- Push: when `imem_valid_i` is high and the response is not squashed, append 2 halfwords (low half first).
  - If the `skip_low` flag is set, append only the high half and clear the flag.
  - Push and pop in the same cycle are both applied.
- Request rule: `imem_req_o` = !redirect_i && (count − pop_amount + 2·outstanding + 2 ≤ 4).
  - At most 1 request is outstanding.
  - `fetch_pc` advances by 4 per issued request.
- Redirect, which has priority over everything else:
  - Queue is flushed (count = 0).
  - Any in-flight response is marked squashed and dropped when it arrives, including one arriving in the same cycle.
  - `fetch_pc` = redirect_pc & ~3; `head_pc` = redirect_pc; `skip_low` = redirect_pc[1].
  - `instr_valid_o` is forced low in the redirect cycle.
- Redirect while stalled: the redirect wins and the held instruction is discarded.
- Queue full (count = 4): no request is issued, and push can never overflow, by the request rule.
- Queue empty with a pending request: `instr_valid_o` stays 0. This is not an error.

## Timing
- All queue, PC and flag state is registered. `instr_*` outputs are combinational from the registered queue head. `imem_req_o` is combinational from state, `stall_i` and `redirect_i`.
- Reset values:
  - `imem_req_o` = 0 while `rst_ni` is low.
  - `imem_addr_o` = `RESET_PC`.
  - `instr_valid_o` = 0, `instr_o` = 0, `instr_is_c_o` = 0, `instr_pc_o` = `RESET_PC`.
  - count = 0, outstanding = 0, `skip_low` = 0.
- After reset: the first request is issued in the first cycle after release. `instr_valid_o` goes high 2 cycles later.
- Redirect latency: redirect in cycle N → request N+1 → data N+2 → `instr_valid_o` in N+3 (32-bit aligned or compressed target).
  - For a 32-bit instruction at an odd halfword, `instr_valid_o` comes in N+4.
- Steady state with no stalls: one 32-bit instruction per cycle.
- Reset asserted mid-operation: all state returns to reset values immediately. Any outstanding response is ignored.

## Configuration
- `FETCH_RVC_EN` defined: compressed support as described above.
- `FETCH_RVC_EN` undefined:
  - Every instruction is 2 halfwords and `instr_is_c_o` is tied 0.
  - `skip_low` logic is removed and `redirect_pc_i[1]` is ignored (treated as 0).
  - The queue becomes 2 words deep and is consumed a word at a time.

## Structure
- Shared package `core_pkg`:
  - `XLEN`
  - opcode-low constant `OPC_LEN32 = 2'b11`
  - typedef `hword_t` (logic [15:0])
  - `RESET_PC` default
- One sub-module: `hword_queue`, a 4-entry halfword FIFO with variable push (1/2) and pop (1/2) and a count output. `fetch_aligner` holds the PC, request and redirect logic.

## Test plan
- Reset, then a stream of 32-bit words at 0x0, 0x4, 0x8 with no stalls → `instr_pc_o` = 0x0, 0x4, 0x8 on consecutive cycles; first valid 2 cycles after reset release.
- Words 0x0001_4501 (two compressed) then 0x0000_0013 → instructions 0x4501 @0x0 and 0x0001 @0x2 with `instr_is_c_o` = 1, then 0x13 @0x4.
- Straddle: word@0 = {0x0513 (low half of a 32-bit instruction), 0x4505 (compressed)}, word@4 = {0x0000, …} → 0x4505 @0x0 compressed, then 0x0000_0513 @0x2 valid only after word@4 arrives.
- `redirect_i` with `redirect_pc_i` = 0x102 in the same cycle as an arriving response → response dropped; next `imem_addr_o` = 0x100; first instruction `instr_pc_o` = 0x102; low half of word 0x100 never presented.
- Hold `stall_i` high for 5 cycles with the queue filling → `imem_req_o` drops at count 4 and the head stays stable. Release stall → no halfword is lost or duplicated.
- Assert `rst_ni` low with a request outstanding → outputs return to reset values immediately; the stale `imem_valid_i` is ignored after release.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: constants and types shared by the fetch stage.
//   XLEN      - address/data width
//   OPC_LEN32 - opcode low bits marking a 32-bit instruction
//   RESET_PC  - default first fetch address
//   hword_t   - one 16-bit instruction parcel
package core_pkg;
   localparam int unsigned XLEN      = 32;
   localparam logic [1:0]  OPC_LEN32 = 2'b11;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   typedef logic [15:0] hword_t;
endpackage

// File: rtl/fetch_aligner_hword_queue.sv
// hword_queue: 4-entry halfword FIFO, entry 0 is the head.
//   clk_i, rst_ni          - clock, async active-low reset
//   flush_i                - empty the queue (wins over push/pop)
//   push_n_i               - halfwords appended this cycle (0/1/2)
//   push_lo_i, push_hi_i   - first and second halfword to append
//   pop_n_i                - halfwords removed from the head (0/1/2)
//   count_o                - occupancy 0..4
//   head0_o, head1_o       - entries 0 and 1
module hword_queue
   import core_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       flush_i,
   input  logic [1:0] push_n_i,
   input  hword_t     push_lo_i,
   input  hword_t     push_hi_i,
   input  logic [1:0] pop_n_i,
   output logic [2:0] count_o,
   output hword_t     head0_o,
   output hword_t     head1_o
);
   hword_t [3:0] r_q;
   logic   [2:0] r_count;
   hword_t [3:0] w_q_nxt;
   logic   [2:0] w_rem;
   logic   [2:0] w_cnt_nxt;

   // Pop shifts the array down; push lands right after the surviving entries.
   always_comb begin
      w_rem     = r_count - {1'b0, pop_n_i};
      w_q_nxt   = r_q >> {pop_n_i, 4'b0000};
      w_cnt_nxt = w_rem + {1'b0, push_n_i};
      for (int unsigned i = 0; i < 4; i++) begin
         if (push_n_i != 2'd0 && 3'(i) == w_rem)         w_q_nxt[2'(i)] = push_lo_i;
         if (push_n_i == 2'd2 && 3'(i) == w_rem + 3'd1)  w_q_nxt[2'(i)] = push_hi_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_q     <= '0;
         r_count <= '0;
      end else if (flush_i) begin
         r_count <= '0;
      end else begin
         r_q     <= w_q_nxt;
         r_count <= w_cnt_nxt;
      end
   end

   assign count_o = r_count;
   assign head0_o = r_q[0];
   assign head1_o = r_q[1];
endmodule

// File: rtl/fetch_aligner.sv
// fetch_aligner: instruction fetch and realignment stage.
// Issues word-aligned imem requests (1-cycle response latency), queues the
// returned halfwords and presents one whole instruction per cycle with its PC.
// Redirects flush the queue and restart fetch.
//   imem_req_o/addr_o      - fetch request / word address
//   imem_rdata_i/valid_i   - response to last cycle's request
//   redirect_i/pc_i        - flush and restart at a halfword-aligned PC
//   stall_i                - hold the head instruction
//   instr_valid_o/instr_o/instr_is_c_o/instr_pc_o - head instruction
// Build option: FETCH_RVC_EN enables compressed (16-bit) instructions;
// without it every instruction is one word and redirect_pc_i[1] is ignored.
module fetch_aligner #(
   parameter int unsigned     XLEN     = core_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic [31:0]     imem_rdata_i,
   input  logic            imem_valid_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            stall_i,
   output logic            instr_valid_o,
   output logic [31:0]     instr_o,
   output logic            instr_is_c_o,
   output logic [XLEN-1:0] instr_pc_o
);
   import core_pkg::*;

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_head_pc;
   logic            r_outstanding;
`ifdef FETCH_RVC_EN
   logic            r_skip_low;
`endif

   logic [2:0]      w_count;
   hword_t          w_h0, w_h1, w_push_lo;
   logic            w_head_c, w_valid, w_accept, w_req;
   logic [1:0]      w_pop_n, w_push_n, w_q_push_n;
   logic [3:0]      w_budget;
   logic [XLEN-1:0] w_redir_head;

`ifdef FETCH_RVC_EN
   assign w_head_c     = (w_h0[1:0] != OPC_LEN32);
   assign w_valid      = !redirect_i && ((w_count >= 3'd1 && w_head_c) || w_count >= 3'd2);
   assign w_push_n     = r_skip_low ? 2'd1 : 2'd2;
   assign w_push_lo    = r_skip_low ? imem_rdata_i[31:16] : imem_rdata_i[15:0];
   assign w_redir_head = redirect_pc_i;
`else
   assign w_head_c     = 1'b0;
   assign w_valid      = !redirect_i && (w_count >= 3'd2);
   assign w_push_n     = 2'd2;
   assign w_push_lo    = imem_rdata_i[15:0];
   assign w_redir_head = redirect_pc_i & ~XLEN'(2);
`endif

   always_comb begin
      w_pop_n = 2'd0;
      if (w_valid && !stall_i) w_pop_n = w_head_c ? 2'd1 : 2'd2;
   end

   // With a fixed 1-cycle latency the only response that can be in flight at
   // a redirect is the one arriving that same cycle, so squashing reduces to
   // gating the push with !redirect_i. Gating with r_outstanding also drops
   // stray responses after reset.
   assign w_accept   = imem_valid_i && r_outstanding && !redirect_i;
   assign w_q_push_n = w_accept ? w_push_n : 2'd0;

   // Room check: queue after pop, plus the in-flight word, plus this request.
   assign w_budget = 4'(w_count) + {2'b00, r_outstanding, 1'b0} + 4'd2 - 4'(w_pop_n);
   assign w_req    = rst_ni && !redirect_i && (w_budget <= 4'd4);

   hword_queue u_queue (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .flush_i   (redirect_i),
      .push_n_i  (w_q_push_n),
      .push_lo_i (w_push_lo),
      .push_hi_i (imem_rdata_i[31:16]),
      .pop_n_i   (w_pop_n),
      .count_o   (w_count),
      .head0_o   (w_h0),
      .head1_o   (w_h1)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fetch_pc    <= RESET_PC;
         r_head_pc     <= RESET_PC;
         r_outstanding <= 1'b0;
`ifdef FETCH_RVC_EN
         r_skip_low    <= 1'b0;
`endif
      end else if (redirect_i) begin
         r_fetch_pc    <= redirect_pc_i & ~XLEN'(3);
         r_head_pc     <= w_redir_head;
         r_outstanding <= 1'b0;
`ifdef FETCH_RVC_EN
         r_skip_low    <= redirect_pc_i[1];
`endif
      end else begin
         r_outstanding <= w_req;
         if (w_req) r_fetch_pc <= r_fetch_pc + XLEN'(4);
         r_head_pc <= r_head_pc + XLEN'({w_pop_n, 1'b0});
`ifdef FETCH_RVC_EN
         if (w_accept) r_skip_low <= 1'b0;
`endif
      end
   end

   assign imem_req_o    = w_req;
   assign imem_addr_o   = r_fetch_pc;
   assign instr_valid_o = w_valid;
   assign instr_o       = !w_valid ? '0 : (w_head_c ? {16'h0000, w_h0} : {w_h1, w_h0});
   assign instr_is_c_o  = w_valid && w_head_c;
   assign instr_pc_o    = r_head_pc;
endmodule

// File: tb/tb_fetch_aligner.sv
// Testbench for fetch_aligner: behavioural imem plus a reference model that
// tracks queue occupancy as a list of halfword addresses and derives the
// expected instruction from the memory image at the expected PC.
module tb_fetch_aligner;
   localparam logic [31:0] RST_PC = 32'h0;
`ifdef FETCH_RVC_EN
   localparam bit RVC = 1'b1;
`else
   localparam bit RVC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        imem_valid_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        stall_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic        instr_is_c_o;
   logic [31:0] instr_pc_o;

   fetch_aligner #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_rdata_i(imem_rdata_i), .imem_valid_i(imem_valid_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .stall_i(stall_i),
      .instr_valid_o(instr_valid_o), .instr_o(instr_o),
      .instr_is_c_o(instr_is_c_o), .instr_pc_o(instr_pc_o)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [256];
   int checks = 0;
   int errors = 0;

   int unsigned mq[$];
   logic [31:0] m_head, m_fetch, m_oaddr;
   logic        m_out, m_skip;

   logic        dut_pend, force_valid;
   logic [31:0] dut_addr;
   logic        drv_redir, drv_stall;
   logic [31:0] drv_rpc;
   logic [98:0] exp_vec, obs_vec;   // {req, addr, valid, instr, is_c, pc}
   logic [31:0] pres_q[$];

   function automatic logic [15:0] mhw(input logic [31:0] a);
      logic [31:0] w;
      w = mem[a[9:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   function automatic int ilen(input logic [31:0] a);
      logic [15:0] h;
      h = mhw(a);
      return (RVC && h[1:0] != 2'b11) ? 1 : 2;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_head = RST_PC; m_fetch = RST_PC; m_oaddr = '0;
      m_out = 1'b0; m_skip = 1'b0; dut_pend = 1'b0; dut_addr = '0;
   endtask

   // One clock: entered at a negedge, drives inputs, samples, advances model.
   task automatic cycle();
      logic [15:0] hw0;
      logic [31:0] ei;
      logic        ev, er, v;
      int          len, pop;
      v = dut_pend | force_valid;
      imem_valid_i  = v;
      imem_rdata_i  = dut_pend ? mem[dut_addr[9:2]] : $urandom;
      redirect_i    = drv_redir;
      redirect_pc_i = drv_rpc;
      stall_i       = drv_stall;
      #1;
      len = ilen(m_head);
      hw0 = mhw(m_head);
      ev  = !drv_redir && (mq.size() >= len);
      ei  = '0;
      if (ev) ei = (len == 1) ? {16'h0000, hw0} : {mhw(m_head + 32'd2), hw0};
      pop = (ev && !drv_stall) ? len : 0;
      er  = !drv_redir && (mq.size() - pop + 2 * int'(m_out) + 2 <= 4);
      exp_vec = {er, m_fetch, ev, ei, ev && (len == 1), m_head};
      obs_vec = {imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_is_c_o, instr_pc_o};
      if (instr_valid_o && !drv_stall) pres_q.push_back(instr_pc_o);
      dut_pend = imem_req_o;
      dut_addr = imem_addr_o;
      if (drv_redir) begin
         mq.delete();
         m_fetch = drv_rpc & ~32'h3;
         m_head  = RVC ? drv_rpc : (drv_rpc & ~32'h2);
         m_skip  = RVC && drv_rpc[1];
         m_out   = 1'b0;
      end else begin
         repeat (pop) void'(mq.pop_front());
         m_head = m_head + 32'(2 * pop);
         if (m_out && v) begin
            if (m_skip) mq.push_back(m_oaddr + 2);
            else begin
               mq.push_back(m_oaddr);
               mq.push_back(m_oaddr + 2);
            end
            m_skip = 1'b0;
         end
         m_out = er;
         if (er) begin
            m_oaddr = m_fetch;
            m_fetch = m_fetch + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; imem_valid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
      redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0;
      force_valid = 1'b0; drv_redir = 1'b0; drv_rpc = '0; drv_stall = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      obs_vec = {imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_is_c_o, instr_pc_o};
      checks++;
      if (obs_vec !== {1'b0, RST_PC, 1'b0, 32'h0, 1'b0, RST_PC}) begin
         errors++; $display("FAIL reset_values obs=%h exp=%h", obs_vec, {1'b0, RST_PC, 1'b0, 32'h0, 1'b0, RST_PC});
      end
      @(negedge clk);
      rst_ni = 1'b1;
   endtask

   task automatic test_stream();
      int first = -1;
      logic [31:0] pcs[$];
      for (int i = 0; i < 12; i++) begin
         cycle();
         checks++;
         if (obs_vec !== exp_vec) begin errors++; $display("FAIL stream_cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec); end
         if (obs_vec[65]) begin
            if (first < 0) first = i;
            pcs.push_back(obs_vec[31:0]);
         end
      end
      checks++;
      if (first != 2) begin errors++; $display("FAIL stream_first_valid got=%0d want=2", first); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (pcs.size() <= k) begin errors++; $display("FAIL stream_pc%0d missing", k); end
         else if (pcs[k] !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc%0d got=%h want=%h", k, pcs[k], 32'(4 * k)); end
      end
   endtask

`ifdef FETCH_RVC_EN
   task automatic test_compressed();
      logic [31:0] ci[$], cp[$];
      logic        cc[$];
      logic [31:0] wi[3] = '{32'h0000_4501, 32'h0000_0001, 32'h0000_0013};
      logic [31:0] wp[3] = '{32'h0, 32'h2, 32'h4};
      logic        wc[3] = '{1'b1, 1'b1, 1'b0};
      mem[0] = 32'h0001_4501; mem[1] = 32'h0000_0013;
      drv_redir = 1'b1; drv_rpc = 32'h0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         drv_redir = 1'b0;
         checks++;
         if (obs_vec !== exp_vec) begin errors++; $display("FAIL rvc_cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec); end
         if (obs_vec[65]) begin ci.push_back(obs_vec[64:33]); cp.push_back(obs_vec[31:0]); cc.push_back(obs_vec[32]); end
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ci.size() <= k) begin errors++; $display("FAIL rvc_instr%0d missing", k); end
         else if ({ci[k], cp[k], cc[k]} !== {wi[k], wp[k], wc[k]}) begin
            errors++; $display("FAIL rvc_instr%0d got=%h@%h c=%b want=%h@%h c=%b", k, ci[k], cp[k], cc[k], wi[k], wp[k], wc[k]);
         end
      end
   endtask

   task automatic test_straddle();
      logic [31:0] ci[$], cp[$];
      logic        cc[$];
      mem[0] = 32'h0513_4505; mem[1] = 32'h1234_0000;
      drv_redir = 1'b1; drv_rpc = 32'h0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         drv_redir = 1'b0;
         checks++;
         if (obs_vec !== exp_vec) begin errors++; $display("FAIL straddle_cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec); end
         if (obs_vec[65]) begin ci.push_back(obs_vec[64:33]); cp.push_back(obs_vec[31:0]); cc.push_back(obs_vec[32]); end
      end
      checks++;
      if (ci.size() < 2) begin errors++; $display("FAIL straddle_count got=%0d want>=2", ci.size()); end
      else if ({ci[0], cp[0], cc[0], ci[1], cp[1], cc[1]} !== {32'h4505, 32'h0, 1'b1, 32'h0000_0513, 32'h2, 1'b0}) begin
         errors++; $display("FAIL straddle_pair got=%h@%h,%h@%h want=4505@0,513@2", ci[0], cp[0], ci[1], cp[1]);
      end
   endtask
`endif

   task automatic test_redirect(input logic [31:0] rpc, input int exp_lat, input logic [31:0] exp_pc);
      int lat = -1;
      for (int i = 0; i < 6 && !dut_pend; i++) cycle();
      checks++;
      if (!dut_pend) begin errors++; $display("FAIL redirect_setup no pending response"); end
      drv_redir = 1'b1; drv_rpc = rpc;
      cycle();
      drv_redir = 1'b0;
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL redirect_cyc obs=%h exp=%h", obs_vec, exp_vec); end
      for (int n = 1; n <= 8 && lat < 0; n++) begin
         cycle();
         checks++;
         if (obs_vec !== exp_vec) begin errors++; $display("FAIL redirect_n%0d obs=%h exp=%h", n, obs_vec, exp_vec); end
         if (n == 1) begin
            checks++;
            if (obs_vec[98:66] !== {1'b1, rpc & ~32'h3}) begin
               errors++; $display("FAIL redirect_req got=%h want=%h", obs_vec[98:66], {1'b1, rpc & ~32'h3});
            end
         end
         if (obs_vec[65]) begin
            lat = n;
            checks++;
            if (obs_vec[31:0] !== exp_pc) begin errors++; $display("FAIL redirect_pc got=%h want=%h", obs_vec[31:0], exp_pc); end
         end
      end
      checks++;
      if (lat != exp_lat) begin errors++; $display("FAIL redirect_latency got=%0d want=%0d", lat, exp_lat); end
   endtask

   task automatic test_stall();
      logic [31:0] held_i, held_p;
      logic        held_v;
      for (int i = 0; i < 4; i++) cycle();
      pres_q.delete();
      drv_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         checks++;
         if (obs_vec !== exp_vec) begin errors++; $display("FAIL stall_cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec); end
         if (i == 0) begin
            held_v = obs_vec[65]; held_i = obs_vec[64:33]; held_p = obs_vec[31:0];
         end else begin
            checks++;
            if ({obs_vec[65], obs_vec[64:33], obs_vec[31:0]} !== {held_v, held_i, held_p}) begin
               errors++; $display("FAIL stall_hold%0d got=%h@%h want=%h@%h", i, obs_vec[64:33], obs_vec[31:0], held_i, held_p);
            end
         end
      end
      checks++;
      if (obs_vec[98] !== 1'b0) begin errors++; $display("FAIL stall_req_full got=%b want=0", obs_vec[98]); end
      drv_stall = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         checks++;
         if (obs_vec !== exp_vec) begin errors++; $display("FAIL unstall_cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec); end
      end
      checks++;
      if (pres_q.size() < 4) begin errors++; $display("FAIL stall_presented got=%0d want>=4", pres_q.size()); end
      for (int k = 0; k + 1 < pres_q.size(); k++) begin
         checks++;
         if (pres_q[k + 1] !== pres_q[k] + 32'(2 * ilen(pres_q[k]))) begin
            errors++; $display("FAIL stall_seq%0d got=%h want=%h", k, pres_q[k + 1], pres_q[k] + 32'(2 * ilen(pres_q[k])));
         end
      end
   endtask

   task automatic test_random();
      for (int w = 0; w < 256; w++) mem[w] = $urandom;
      for (int i = 0; i < 400; i++) begin
         drv_stall = ($urandom_range(0, 3) == 0);
         drv_redir = (i == 0) || ($urandom_range(0, 29) == 0);
         drv_rpc   = (i == 0) ? 32'h0 : {22'h0, 9'($urandom_range(0, 511)), 1'b0};
         cycle();
         checks++;
         if (obs_vec !== exp_vec) begin errors++; $display("FAIL random_cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec); end
      end
      drv_stall = 1'b0; drv_redir = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 6 && !dut_pend; i++) cycle();
      rst_ni = 1'b0;
      imem_valid_i = 1'b1;
      #1;
      obs_vec = {imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_is_c_o, instr_pc_o};
      checks++;
      if (obs_vec !== {1'b0, RST_PC, 1'b0, 32'h0, 1'b0, RST_PC}) begin
         errors++; $display("FAIL midreset_values obs=%h exp=%h", obs_vec, {1'b0, RST_PC, 1'b0, 32'h0, 1'b0, RST_PC});
      end
      @(negedge clk);
      rst_ni = 1'b1;
      model_reset();
      force_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         force_valid = 1'b0;
         checks++;
         if (obs_vec !== exp_vec) begin errors++; $display("FAIL midreset_cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec); end
      end
   endtask

   initial begin
      for (int w = 0; w < 256; w++) mem[w] = $urandom;
      for (int w = 0; w < 16; w++) mem[w] = $urandom | 32'h3;
      mem[8'h40] = 32'h4505_0513;
      mem[8'h41] = 32'h0593_4501;
      mem[8'h42] = 32'h0000_0000;
      mem[8'h43] = 32'h0000_0013;
      test_reset();
      test_stream();
      test_redirect(32'h102, 3, RVC ? 32'h102 : 32'h100);
`ifdef FETCH_RVC_EN
      test_redirect(32'h106, 4, 32'h106);
`endif
      test_stall();
`ifdef FETCH_RVC_EN
      test_compressed();
      test_straddle();
`endif
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
